peak_record_packetizer: RTL

Receive-side consumer of the range detector's single-beat 256-bit peak-record AXI-Stream. Buffers records in a small FIFO and serializes each into a framed 5-beat 64-bit AXI-Stream packet: a header beat plus four data beats. The output stream feeds the Ethernet/host transmit path.

---
 rtl/peak_record_packetizer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/peak_record_packetizer.sv
// peak_record_packetizer
// Buffers 256-bit peak records in a small FIFO and serializes each one into
// a 5-beat 64-bit AXI-Stream packet: {HDR_MAGIC, seq} header + 4 data beats.
// Optional feature macro: PK_PKT_DROP_EN (never stall upstream, count drops).
module peak_record_packetizer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] HDR_MAGIC  = 32'h504B504B
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [255:0]                s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [63:0]                 m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [7:0]                  m_axis_tkeep,
  input  logic                        m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 pkt_count,
  output logic [31:0]                 drop_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef logic [PW:0]   lvl_t;
  typedef logic [PW-1:0] ptr_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [255:0] mem_q [FIFO_DEPTH];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  lvl_t         level_q, level_d;
  state_t       state_q, state_d;
  logic [2:0]   beat_q, beat_d;
  logic [255:0] rec_q, rec_d;
  logic [63:0]  tdata_q, tdata_d;
  logic         tvalid_q, tvalid_d;
  logic         tlast_q, tlast_d;
  logic [31:0]  pkt_q, pkt_d;

  logic         full, empty, wr_en, pop;
  logic [255:0] head;

  // Every accepted beat is a whole record, so tlast carries no information.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  assign full  = (level_q == lvl_t'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

`ifdef PK_PKT_DROP_EN
  logic [31:0] drop_q, drop_d;
  logic        drop_ev;

  assign s_axis_tready = 1'b1;
  assign wr_en         = s_axis_tvalid & ~full;
  assign drop_ev       = s_axis_tvalid & full;
  assign drop_count    = drop_q;

  // Saturating count of records discarded while the FIFO is full.
  always_comb begin
    drop_d = drop_q;
    if (drop_ev && (drop_q != '1)) begin
      drop_d = drop_q + 32'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end
`else
  assign s_axis_tready = ~full;
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign drop_count    = '0;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = 8'hFF;
  assign fifo_level    = level_q;
  assign pkt_count     = pkt_q;

  function automatic logic [63:0] data_beat(input logic [2:0] b, input logic [255:0] rec);
    case (b)
      3'd1:    data_beat = rec[255:192];
      3'd2:    data_beat = rec[191:128];
      3'd3:    data_beat = rec[127:64];
      default: data_beat = rec[63:0];
    endcase
  endfunction

  // Record storage; no reset needed since the pointers gate every read.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  // Serializer next-state, output beat generation and FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rec_d    = rec_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    pkt_d    = pkt_q;
    pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          rec_d    = head;
          beat_d   = 3'd0;
          state_d  = SEND;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = {HDR_MAGIC, pkt_q};
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (beat_q == 3'd4) begin
            pkt_d = pkt_q + 32'd1;
            // Header of a chained packet must already carry the incremented count.
            if (!empty) begin
              pop      = 1'b1;
              rec_d    = head;
              beat_d   = 3'd0;
              tvalid_d = 1'b1;
              tlast_d  = 1'b0;
              tdata_d  = {HDR_MAGIC, pkt_q + 32'd1};
            end else begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end
          end else begin
            beat_d  = beat_q + 3'd1;
            tdata_d = data_beat(beat_q + 3'd1, rec_q);
            tlast_d = (beat_q == 3'd3);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    level_d  = level_q + lvl_t'(wr_en) - lvl_t'(pop);
  end

  // State, datapath and FIFO pointer registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      rec_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      pkt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rec_q    <= rec_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      pkt_q    <= pkt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
